// File: rtl/act_stream_reader.sv
// act_stream_reader: reads a run of bytes from activation SRAM and streams them
// out on a valid/ready byte interface, buffered by a small FIFO.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle launch (sampled in IDLE only)
//   base_addr         first SRAM address, captured on start
//   num_elements      transfer length, captured on start
//   busy, done        status; done pulses for one cycle at the end
//   mem_rd_en/addr    SRAM read request (1-cycle read latency)
//   mem_rd_data       SRAM read data, valid the cycle after mem_rd_en
//   data_out          stream data (FIFO head)
//   out_valid         stream valid (FIFO non-empty)
//   out_ready         downstream accept
module act_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_ELEMENTS = 4096,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [$clog2(MAX_ELEMENTS+1)-1:0] num_elements,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rd_data,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int LENW = $clog2(MAX_ELEMENTS + 1);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LENW-1:0]       r_len;
    logic [LENW-1:0]       r_rd_issued;
    logic [LENW-1:0]       r_out_count;
    logic                  r_inflight;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTRW-1:0]       r_wptr;
    logic [PTRW-1:0]       r_rptr;
    logic [CNTW-1:0]       r_count;

    logic                  w_rd_en;
    logic                  w_push;
    logic                  w_pop;
    logic [CNTW-1:0]       w_used;

    // Credits: buffered entries plus the read whose data lands next cycle.
    assign w_used  = r_count + CNTW'(r_inflight);
    assign w_rd_en = (r_state == S_STREAM)
                   && (r_rd_issued < r_len)
                   && (w_used < CNTW'(FIFO_DEPTH));
    assign w_push  = r_inflight;
    assign w_pop   = (r_count != '0) && out_ready;

    assign mem_rd_en   = w_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign out_valid   = (r_count != '0);
    assign data_out    = r_fifo[r_rptr];
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_elements == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_rd_en && (r_rd_issued + LENW'(1) == r_len)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_out_count + LENW'(1) == r_len)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_len       <= '0;
            r_rd_issued <= '0;
            r_out_count <= '0;
            r_inflight  <= 1'b0;
        end else begin
            // Cleared on every reset so a return from an aborted read is dropped.
            r_inflight <= w_rd_en;
            if ((r_state == S_IDLE) && start) begin
                r_rd_addr   <= base_addr;
                r_len       <= num_elements;
                r_rd_issued <= '0;
                r_out_count <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_addr   <= r_rd_addr + ADDR_WIDTH'(1);
                    r_rd_issued <= r_rd_issued + LENW'(1);
                end
                if (w_pop) begin
                    r_out_count <= r_out_count + LENW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= mem_rd_data;
                r_wptr         <= r_wptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTRW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_act_stream_reader.sv
// tb_act_stream_reader: self-checking bench for act_stream_reader.
// Drives scenario tasks against an SRAM array and an expected-byte model.
module tb_act_stream_reader;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int LW    = 13;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] num_elements;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] sram [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];
    end

    act_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_elements (num_elements),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        num_elements = '0;
        mem_rd_data = '0;
        tick();
        tick();
        checks++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000",
                     {busy, done, mem_rd_en, out_valid});
        checks++;
        if (mem_rd_addr !== 16'h0000 || data_out !== 8'h00)
            $display("FAIL reset_data got addr=%h data=%h exp 0000/00",
                     mem_rd_addr, data_out);
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0000 ||
            mem_rd_addr !== 16'h0000 || data_out !== 8'h00)
            errors++;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b exp=0", busy);
        end
    endtask

    task automatic test_basic;
        logic          exp_en, exp_v;
        logic [AW-1:0] ea;
        base_addr = 16'h0100;
        num_elements = 13'd8;
        out_ready = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            start = (c == 0);
            exp_en = (c >= 1 && c <= 8);
            exp_v = (c >= 3 && c <= 10);
            checks++;
            if (mem_rd_en !== exp_en) begin
                errors++;
                $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, mem_rd_en, exp_en);
            end
            if (exp_en) begin
                ea = 16'h0100 + 16'(c - 1);
                checks++;
                if (mem_rd_addr !== ea) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d got=%h exp=%h", c, mem_rd_addr, ea);
                end
            end
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL basic_valid c=%0d got=%b exp=%b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (data_out !== 8'(c - 3)) begin
                    errors++;
                    $display("FAIL basic_data c=%0d got=%h exp=%h", c, data_out, 8'(c - 3));
                end
            end
            checks++;
            if (done !== (c == 11) || busy !== (c >= 1 && c <= 11)) begin
                errors++;
                $display("FAIL basic_status c=%0d got done=%b busy=%b", c, done, busy);
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [AW-1:0] addrs[$];
        logic [DW-1:0] got[$];
        int            dones;
        bit            fin;
        base_addr = 16'h0100;
        num_elements = 13'd8;
        out_ready = 1'b0;
        dones = 0;
        fin = 0;
        for (int c = 0; c <= 9; c++) begin
            start = (c == 0);
            if (mem_rd_en) addrs.push_back(mem_rd_addr);
            if (c >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== 8'h00) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d got v=%b d=%h exp v=1 d=00",
                             c, out_valid, data_out);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (addrs.size() != 4) begin
            errors++;
            $display("FAIL bp_read_count got=%0d exp=4", addrs.size());
        end
        out_ready = 1'b1;
        for (int c = 0; c < 200 && !fin; c++) begin
            if (mem_rd_en) addrs.push_back(mem_rd_addr);
            if (out_valid) got.push_back(data_out);
            if (done) begin
                dones++;
                fin = 1;
            end
            tick();
        end
        checks++;
        if (!fin || dones != 1) begin
            errors++;
            $display("FAIL bp_done got fin=%0d dones=%0d exp 1/1", fin, dones);
        end
        checks++;
        if (addrs.size() != 8 || got.size() != 8) begin
            errors++;
            $display("FAIL bp_sizes got reads=%0d outs=%0d exp 8/8",
                     addrs.size(), got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (addrs[i] !== 16'(16'h0100 + i) || got[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL bp_seq i=%0d got a=%h d=%h exp a=%h d=%h",
                             i, addrs[i], got[i], 16'(16'h0100 + i), 8'(i));
                end
            end
        end
    endtask

    task automatic test_random;
        int            n_out, n_rd, dones, seq_err;
        bit            fin, pv, pr;
        logic [DW-1:0] pd;
        base_addr = 16'h0000;
        num_elements = 13'd300;
        n_out = 0;
        n_rd = 0;
        dones = 0;
        seq_err = 0;
        fin = 0;
        pv = 0;
        pr = 0;
        pd = '0;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== pd) begin
                    errors++;
                    $display("FAIL rand_stable c=%0d got v=%b d=%h exp v=1 d=%h",
                             c, out_valid, data_out, pd);
                end
            end
            if (mem_rd_en) begin
                if (mem_rd_addr !== 16'(n_rd)) seq_err++;
                n_rd++;
            end
            if (n_rd - n_out > DEPTH) seq_err++;
            if (out_valid && out_ready) begin
                if (n_out >= 300 || data_out !== sram[16'(n_out)]) begin
                    errors++;
                    $display("FAIL rand_data idx=%0d got=%h exp=%h",
                             n_out, data_out, sram[16'(n_out)]);
                end
                checks++;
                n_out++;
            end
            if (done) begin
                dones++;
                fin = 1;
            end
            pv = out_valid;
            pr = out_ready;
            pd = data_out;
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (done) dones++;
            if (out_valid || mem_rd_en) seq_err++;
            tick();
        end
        checks++;
        if (seq_err != 0) begin
            errors++;
            $display("FAIL rand_seq got violations=%0d exp=0", seq_err);
        end
        checks++;
        if (dones != 1 || n_out != 300 || n_rd != 300) begin
            errors++;
            $display("FAIL rand_totals got dones=%0d outs=%0d reads=%0d exp 1/300/300",
                     dones, n_out, n_rd);
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] addrs[$];
        logic [DW-1:0] got[$];
        logic [AW-1:0] ea;
        bit            fin;
        base_addr = 16'hFFFE;
        num_elements = 13'd4;
        out_ready = 1'b1;
        fin = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (mem_rd_en) addrs.push_back(mem_rd_addr);
            if (out_valid) got.push_back(data_out);
            if (done) fin = 1;
            tick();
        end
        checks++;
        if (!fin || addrs.size() != 4 || got.size() != 4) begin
            errors++;
            $display("FAIL wrap_sizes got fin=%0d reads=%0d outs=%0d exp 1/4/4",
                     fin, addrs.size(), got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ea = 16'hFFFE + 16'(i);
                checks++;
                if (addrs[i] !== ea || got[i] !== sram[ea]) begin
                    errors++;
                    $display("FAIL wrap_seq i=%0d got a=%h d=%h exp a=%h d=%h",
                             i, addrs[i], got[i], ea, sram[ea]);
                end
            end
        end
    endtask

    task automatic test_zero;
        int bad;
        bad = 0;
        base_addr = 16'h1234;
        num_elements = 13'd0;
        out_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            start = (c == 0);
            if (mem_rd_en || out_valid) bad++;
            checks++;
            if (done !== (c == 1) || busy !== (c == 1)) begin
                errors++;
                $display("FAIL zero_status c=%0d got done=%b busy=%b exp %b/%b",
                         c, done, busy, c == 1, c == 1);
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_activity got=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] got[$];
        int            bad;
        bit            fin;
        bad = 0;
        fin = 0;
        base_addr = 16'h0100;
        num_elements = 13'd8;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            tick();
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0000 ||
            mem_rd_addr !== 16'h0000 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_outputs got flags=%b addr=%h data=%h exp 0",
                     {busy, done, mem_rd_en, out_valid}, mem_rd_addr, data_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done || busy || out_valid || mem_rd_en) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_quiet got=%0d exp=0", bad);
        end
        base_addr = 16'h0200;
        num_elements = 13'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && !fin; c++) begin
            if (out_valid) got.push_back(data_out);
            if (done) fin = 1;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            if (out_valid) got.push_back(data_out);
            tick();
        end
        checks++;
        if (!fin || got.size() != 3) begin
            errors++;
            $display("FAIL rstmid_fresh got fin=%0d outs=%0d exp 1/3", fin, got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== sram[16'(16'h0200 + i)]) begin
                    errors++;
                    $display("FAIL rstmid_data i=%0d got=%h exp=%h",
                             i, got[i], sram[16'(16'h0200 + i)]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) sram[16'h0100 + i] = 8'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_wrap();
        test_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/act_stream_reader.md
Name: act_stream_reader

Overview:
- Streaming source that feeds the activation engines (GELU and similar) from on-chip activation SRAM.
- On start, reads num_elements consecutive bytes beginning at base_addr through a 1-cycle-latency SRAM read port.
- Presents the bytes in order on a valid/ready byte stream, buffering them in a small FIFO so back-pressure never loses SRAM return data.
- Pulses done after the last byte has been accepted downstream.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- ADDR_WIDTH, 16, SRAM byte-address width.
- MAX_ELEMENTS, 4096, largest transfer length.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle launch request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first SRAM address; captured on start.
- num_elements  in  $clog2(MAX_ELEMENTS+1)  transfer length; captured on start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse, high in DONE.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_WIDTH  SRAM read address.
- mem_rd_data  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_rd_en.
- data_out  out  DATA_WIDTH  stream data; equals the FIFO head.
- out_valid  out  1  stream valid; high whenever the FIFO is non-empty.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset: state IDLE. busy, done, mem_rd_en, out_valid all 0. mem_rd_addr, data_out, all counters and FIFO pointers 0.
- One clock (clk). Reset (rst) is asynchronous and active-high.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - On start, capture base_addr and num_elements, then go to STREAM.
  - If the captured num_elements is 0, go directly to DONE instead.
  - start in any other state is ignored.
- STREAM:
  - Issue a read (mem_rd_en=1, mem_rd_addr=rd_addr) when rd_issued < len and fifo_count + inflight < FIFO_DEPTH.
  - inflight is 1 if a read was issued the previous cycle, else 0.
  - rd_addr increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
  - After the final read is issued, go to DRAIN.
- Return path: the cycle after mem_rd_en, write mem_rd_data into the FIFO. The credit rule guarantees the FIFO is never full at that point.
- Output transfer: occurs in any cycle with out_valid && out_ready. It pops the head and increments out_count.
- Simultaneous push and pop leave fifo_count unchanged. A pop on an empty FIFO is impossible because out_valid=0.
- Once asserted, out_valid stays high with data_out stable until accepted.
- DRAIN: no reads. When out_count reaches len (counting the transfer in the current cycle), go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. The FIFO is empty on exit.
- Latency:
  - start sampled at cycle 0; first mem_rd_en in cycle 1.
  - First out_valid in cycle 3: FIFO write at the end of cycle 2, registered head.
  - With out_ready held high, throughput is 1 element/cycle.
  - done occurs 1 cycle after the last transfer.
- Back-pressure: with out_ready low, reads stop once FIFO_DEPTH entries are outstanding (buffered plus in-flight). Reads resume the cycle after a pop frees a credit.
- Reset mid-operation: immediate return to IDLE. The FIFO is flushed, and any SRAM data returning the next cycle is discarded. done does not pulse.
- Counters (rd_issued, out_count) are $clog2(MAX_ELEMENTS+1) bits. num_elements above MAX_ELEMENTS is undefined and not checked.

Test Plan:
- Basic stream: SRAM[0x0100..0x0107] = 0x00,0x01,...,0x07; start with base_addr=0x0100, num_elements=8, out_ready=1. Required: mem_rd_en in cycles 1-8 with addresses 0x0100-0x0107; out_valid in cycles 3-10 with data 0x00..0x07 in order; done pulse in cycle 11; busy low in cycle 12.
- Back-pressure: same data, out_ready=0 for cycles 0-9, then 1. Required: exactly 4 reads issued (0x0100-0x0103), then mem_rd_en stays low; data_out holds 0x00 while out_ready=0; all 8 bytes delivered in order after release with no loss or duplication.
- Random out_ready at 50% over num_elements=300, base_addr=0x0000. Required: output sequence equals SRAM contents; FIFO never overflows (assertion fifo_count <= FIFO_DEPTH); exactly one done pulse.
- Address wrap: base_addr=0xFFFE, num_elements=4. Required: read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero length: num_elements=0. Required: no mem_rd_en and no out_valid; done in cycle 1; IDLE in cycle 2.
- Reset mid-stream: assert rst for 1 cycle during cycle 5 of an 8-element transfer. Required: all outputs 0 immediately; no done pulse; a fresh start of 3 elements afterwards delivers only those 3 bytes.
